regfile_write_arbiter: RTL

- Shares the register file's single write port (RegWrite, Rd, Write_data) among NUM_REQ write-back requesters, e.g. ALU result, load data and debug write.
- Each requester gets a one-entry holding slot with a valid/ready handshake. Pending slots are granted round-robin, one write per cycle.
- Exports a per-register busy mask so decode can stall on RAW hazards against writes not yet committed.

---
 rtl/regfile_write_arbiter_if.sv | 27 ++
 rtl/regfile_write_arbiter.sv | 95 +++++++++
 2 files changed

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: requester handshake plus register-file write port.
// master drives requests and flush; slave is the arbiter.
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                             flush;
    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0]    req_rd;
    logic [NUM_REQ*DATA_WIDTH-1:0]    req_data;
    logic                             RegWrite;
    logic [ADDR_WIDTH-1:0]            Rd;
    logic [DATA_WIDTH-1:0]            Write_data;
    logic [2:0]                       grant_id;
    logic [2**ADDR_WIDTH-1:0]         busy_mask;

    modport master (
        output flush, req_valid, req_rd, req_data,
        input  req_ready, RegWrite, Rd, Write_data, grant_id, busy_mask
    );
    modport slave (
        input  flush, req_valid, req_rd, req_data,
        output req_ready, RegWrite, Rd, Write_data, grant_id, busy_mask
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of the register-file write port
// among NUM_REQ one-entry holding slots, with a per-register busy mask.
module regfile_write_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input logic clk,
    input logic reset,
    regfile_write_arbiter_if.slave bus
);
    localparam int REGS = 2**ADDR_WIDTH;

    logic [NUM_REQ-1:0]    hold_v, sel, ready, accept, conflict;
    logic [ADDR_WIDTH-1:0] hold_rd [NUM_REQ];
    logic [DATA_WIDTH-1:0] hold_data [NUM_REQ];
    logic [2:0]            rr_ptr, gnt, lo, hi;
    logic                  lo_v, hi_v;
    logic [ADDR_WIDTH-1:0] rd_o;
    logic [DATA_WIDTH-1:0] data_o;
    logic [REGS-1:0]       busy;

    // Cyclic scan: lowest held slot at or above rr_ptr, else wrap to the lowest held slot.
    always_comb begin
        lo_v = 1'b0;
        hi_v = 1'b0;
        lo = '0;
        hi = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (hold_v[i]) begin
                lo_v = 1'b1;
                lo = 3'(i);
            end
            if (hold_v[i] && 3'(i) >= rr_ptr) begin
                hi_v = 1'b1;
                hi = 3'(i);
            end
        end
    end

    assign gnt = hi_v ? hi : lo;

    // A slot still being granted counts as a conflict so same-register writes stay ordered.
    always_comb begin
        rd_o = '0;
        data_o = '0;
        busy = '0;
        sel = '0;
        ready = '0;
        accept = '0;
        conflict = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++)
                if (j != i && hold_v[j] && bus.req_rd[i*ADDR_WIDTH +: ADDR_WIDTH] != '0 &&
                    hold_rd[j] == bus.req_rd[i*ADDR_WIDTH +: ADDR_WIDTH])
                    conflict[i] = 1'b1;
            sel[i] = lo_v && gnt == 3'(i);
            if (sel[i]) begin
                rd_o = hold_rd[i];
                data_o = hold_data[i];
            end
            if (hold_v[i]) busy[hold_rd[i]] = 1'b1;
            ready[i] = !reset && !bus.flush && (!hold_v[i] || sel[i]) && !conflict[i];
            accept[i] = bus.req_valid[i] && ready[i];
        end
        busy[0] = 1'b0;
    end

    assign bus.req_ready  = ready;
    assign bus.RegWrite   = lo_v;
    assign bus.Rd         = rd_o;
    assign bus.Write_data = data_o;
    assign bus.grant_id   = gnt;
    assign bus.busy_mask  = busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_v <= '0;
            rr_ptr <= '0;
        end else begin
            if (lo_v) rr_ptr <= gnt == 3'(NUM_REQ - 1) ? 3'd0 : gnt + 3'd1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.flush) begin
                    hold_v[i] <= 1'b0;
                end else if (accept[i]) begin
                    hold_v[i]    <= bus.req_rd[i*ADDR_WIDTH +: ADDR_WIDTH] != '0;
                    hold_rd[i]   <= bus.req_rd[i*ADDR_WIDTH +: ADDR_WIDTH];
                    hold_data[i] <= bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end else if (sel[i]) begin
                    hold_v[i] <= 1'b0;
                end
            end
        end
    end
endmodule
